mem_bus_bridge: RTL and testbench
=================================

// Module: mem_bus_bridge
// PURPOSE
//  Sits directly downstream of the MEM stage and connects its load/store requests to a
//  handshaked data bus with variable latency. Produces the bus strobes, aligns and
//  replicates store data, and sign- or zero-extends load data. Holds the pipeline with
//  `stall` until the access completes, is rejected as misaligned or illegal, or times out.
// PARAMETERS
//  TIMEOUT  255  max cycles spent in ADDR+DATA before abort with fault (counter width 8)
// PORTS
//  clk        in   1   pipeline clock, rising edge
//  reset      in   1   asynchronous, active-high
//  req_valid  in   1   MEM stage holds a load/store this cycle
//  req_write  in   1   1=store, 0=load
//  req_funct3 in   3   000 b, 001 h, 010 w, 100 bu, 101 hu; others illegal
//  req_addr   in   32  byte address from ALU result
//  req_wdata  in   32  rs2 data (store)
//  stall      out  1   freeze IF..MEM registers
//  done       out  1   1-cycle pulse: access finished, rdata/fault valid
//  fault      out  1   qualified by done: misaligned, illegal funct3, bus_err or timeout
//  rdata      out  32  extended load result; 0 for stores and faults
//  bus_valid  out  1   request valid
//  bus_ready  in   1   request accepted when bus_valid&bus_ready
//  bus_we     out  1   write enable
//  bus_addr   out  32  {req_addr[31:2],2'b00}
//  bus_wstrb  out  4   byte enables (0 on reads)
//  bus_wdata  out  32  lane-replicated store data
//  bus_rvalid in   1   response (reads and writes), 1 cycle
//  bus_rdata  in   32  read word
//  bus_err    in   1   error, qualified by bus_rvalid
// BEHAVIOUR
//  FSM states: IDLE, ADDR, DATA, RESP. Reset: state=IDLE, every output 0, counter 0.
//  - stall = req_valid & ~done (combinational); pipeline advances on the done cycle.
//  - IDLE, req_valid, legal and aligned: latch addr/funct3/we/wstrb/wdata, go to ADDR.
//  - IDLE, misaligned (h: addr[0]; w: addr[1:0]!=0) or illegal funct3: go to RESP
//    with fault=1 and no bus activity.
//  - ADDR: bus_valid=1 with fields held stable. bus_valid&bus_ready goes to DATA.
//  - DATA: bus_rvalid goes to RESP; capture rdata and set fault=bus_err.
//  - RESP: done=1, then IDLE. Fault clears rdata to 0.
//  - Timeout counter clears on leaving IDLE and increments in ADDR/DATA. Reaching TIMEOUT
//    goes to RESP with fault=1. Dropping bus_valid on an ADDR abort is permitted.
//  - bus_rvalid outside DATA is ignored. bus_rvalid and timeout in the same cycle: rvalid wins.
//  - Minimum latency: request seen in cycle 0, done in cycle 3 (bus_ready, rvalid immediate).
//  - Strobes: sb 4'b0001<<addr[1:0]; sh 4'b0011<<{addr[1],1'b0}; sw 4'b1111.
//  - Store data: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
//  - Load: shift bus_rdata right by 8*addr[1:0]. lb/lh sign-extend, lbu/lhu zero-extend.
//  - Reset mid-transaction: asynchronously forces IDLE and bus_valid=0; the in-flight
//    response is dropped.
// TESTING
//  1. lw 0x100, ready/rvalid immediate, rdata 0xDEADBEEF -> done cycle 3, rdata 0xDEADBEEF, stall 3 cycles
//  2. lb 0x103, bus_rdata 0x80FF_0000 -> rdata 0xFFFFFF80; lbu -> 0x00000080; lhu 0x102 -> 0x000080FF
//  3. sb 0x201 wdata 0x123456AB -> bus_wstrb 4'b0010, bus_wdata 0xABABABAB, bus_addr 0x200
//  4. lw 0x102 -> no bus_valid, done+fault in cycle 1, rdata 0
//  5. bus_ready held 0, TIMEOUT=255 -> fault+done after 255 ADDR cycles; rvalid with bus_err -> fault
//  6. reset asserted in DATA -> bus_valid/stall/done 0 at once; a later rvalid is ignored

Source files
------------

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: connects MEM-stage load/store requests to a handshaked data bus.
// Generates word address, byte strobes and lane-replicated store data, extends load
// data, and holds the pipeline until the access completes, faults or times out.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for req_valid; illegal/misaligned requests go straight to RESP
// ADDR  | bus_valid high with fields held, waiting for bus_ready
// DATA  | request accepted, waiting for bus_rvalid
// RESP  | done pulse; rdata/fault presented for one cycle
module mem_bus_bridge #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        done,
   output logic        fault,
   output logic [31:0] rdata,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // the counter starts at 0 on the first ADDR cycle, so TIMEOUT cycles end at TIMEOUT-1
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        fault_q, fault_d;

   logic        req_legal;
   logic        req_misaligned;
   logic [3:0]  wstrb_new;
   logic [31:0] wdata_new;
   logic [31:0] rd_shifted;
   logic [31:0] rd_ext;

   // request decode: legality, alignment, strobes and replicated store data
   always_comb begin
      case (req_funct3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
         default:                                req_legal = 1'b0;
      endcase
      req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      case (req_funct3[1:0])
         2'b00: begin
            wstrb_new = 4'b0001 << req_addr[1:0];
            wdata_new = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            wstrb_new = 4'b0011 << {req_addr[1], 1'b0};
            wdata_new = {2{req_wdata[15:0]}};
         end
         default: begin
            wstrb_new = 4'b1111;
            wdata_new = req_wdata;
         end
      endcase
      if (!req_write) begin
         wstrb_new = 4'b0000;
      end
   end

   // load alignment and sign/zero extension of the returned word
   always_comb begin
      rd_shifted = bus_rdata >> {off_q, 3'b000};
      case (funct3_q)
         3'b000:  rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         3'b001:  rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         3'b100:  rd_ext = {24'h000000, rd_shifted[7:0]};
         3'b101:  rd_ext = {16'h0000, rd_shifted[15:0]};
         default: rd_ext = rd_shifted;
      endcase
   end

   // access sequencing, timeout and response capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = 8'd0;
            rdata_d = 32'd0;
            fault_d = 1'b0;
            if (req_valid) begin
               if (!req_legal || req_misaligned) begin
                  state_d = ST_RESP;
                  fault_d = 1'b1;
               end else begin
                  state_d  = ST_ADDR;
                  funct3_d = req_funct3;
                  off_d    = req_addr[1:0];
                  we_d     = req_write;
                  addr_d   = {req_addr[31:2], 2'b00};
                  wstrb_d  = wstrb_new;
                  wdata_d  = wdata_new;
               end
            end
         end
         ST_ADDR: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               fault_d = 1'b1;
            end else if (bus_ready) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            cnt_d = cnt_q + 8'd1;
            if (bus_rvalid) begin
               state_d = ST_RESP;
               fault_d = bus_err;
               rdata_d = (bus_err || we_q) ? 32'd0 : rd_ext;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               fault_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rdata_d = 32'd0;
            fault_d = 1'b0;
         end
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         funct3_q <= 3'd0;
         off_q    <= 2'd0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wstrb_q  <= 4'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
      end
   end

   // stall is also dropped while reset is held so the pipeline is not frozen by a dead access
   assign stall     = req_valid & ~done & ~reset;
   assign done      = (state_q == ST_RESP);
   assign fault     = fault_q;
   assign rdata     = rdata_q;
   assign bus_valid = (state_q == ST_ADDR);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wstrb = wstrb_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Testbench for mem_bus_bridge: directed cases plus randomized loads/stores, a bus
// responder with random latencies, and scoreboards for both the pipeline and bus sides.
`timescale 1ns/1ps
module tb_mem_bus_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        done;
   logic        fault;
   logic [31:0] rdata;
   logic        bus_valid;
   logic        bus_ready;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_bus_bridge #(.TIMEOUT(255)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .done       (done),
      .fault      (fault),
      .rdata      (rdata),
      .bus_valid  (bus_valid),
      .bus_ready  (bus_ready),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wstrb  (bus_wstrb),
      .bus_wdata  (bus_wdata),
      .bus_rvalid (bus_rvalid),
      .bus_rdata  (bus_rdata),
      .bus_err    (bus_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // pipeline-side expectations
   bit          exp_fault_q[$];
   logic [31:0] exp_rdata_q[$];
   // bus-side expectations
   logic [31:0] exp_baddr_q[$];
   bit          exp_bwe_q[$];
   logic [3:0]  exp_bstrb_q[$];
   logic [31:0] exp_bwdata_q[$];

   // responder behaviour for the current access
   int          bm_rd = 0;
   int          bm_vd = 0;
   logic [31:0] bm_word = 32'd0;
   bit          bm_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // access size in bytes, 0 for an illegal code
   function automatic int ref_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
      longint v;
      v = longint'(word >> (8 * int'(off)));
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         3'd4: v = v % 256;
         3'd5: v = v % 65536;
         default: ;
      endcase
      return v[31:0];
   endfunction

   // issue one access and wait for its completion; expectations are queued first
   task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input bit err,
                         input int rd, input int vd);
      int          sz;
      int          lat;
      int          n;
      bit          ef;
      bit          stall_ok;
      logic [31:0] er;
      logic [31:0] mask;
      logic [31:0] rep;
      sz = ref_size(f3);
      if (sz == 0 || (int'(a[1:0]) % sz) != 0) begin
         ef = 1'b1; er = 32'd0; lat = 1;
      end else begin
         mask = ((32'd1 << sz) - 32'd1) << a[1:0];
         if (sz == 1)      rep = (wd % 256) * 32'h0101_0101;
         else if (sz == 2) rep = (wd % 65536) * 32'h0001_0001;
         else              rep = wd;
         exp_baddr_q.push_back(a - (a % 4));
         exp_bwe_q.push_back(we);
         exp_bstrb_q.push_back(we ? mask[3:0] : 4'd0);
         exp_bwdata_q.push_back(rep);
         if (2 + rd + vd > 255) begin
            ef = 1'b1; er = 32'd0; lat = 256;
         end else begin
            ef = err; er = (we || err) ? 32'd0 : ref_load(f3, a[1:0], word);
            lat = 3 + rd + vd;
         end
      end
      exp_fault_q.push_back(ef);
      exp_rdata_q.push_back(er);
      bm_rd = rd; bm_vd = vd; bm_word = word; bm_err = err;
      req_valid = 1'b1; req_write = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      stall_ok = (stall === 1'b1);
      n = 0;
      while (n < 400) begin
         @(posedge clk); #1;
         n++;
         if (done === 1'b1) break;
         if (stall !== 1'b1) stall_ok = 1'b0;
      end
      chk("latency", 32'(n), 32'(lat));
      chk("stall_held", 32'(stall_ok), 32'd1);
      chk("stall_on_done", 32'(stall), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // pipeline-side monitor: every done is matched against the next expectation
   initial begin : mon
      bit          ef;
      logic [31:0] er;
      forever begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            if (exp_fault_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got done=1, expected none at %0t", $time);
            end else begin
               ef = exp_fault_q.pop_front();
               er = exp_rdata_q.pop_front();
               chk("fault", 32'(fault), 32'(ef));
               chk("rdata", rdata, er);
            end
         end
      end
   end

   // bus responder and bus-side monitor
   initial begin : bm
      int k;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus_valid === 1'b1) begin
            if (exp_baddr_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_bus_valid: got bus_valid=1, expected 0 at %0t", $time);
            end else begin
               chk("bus_addr", bus_addr, exp_baddr_q.pop_front());
               chk("bus_we", 32'(bus_we), 32'(exp_bwe_q.pop_front()));
               chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_bstrb_q.pop_front()));
               if (bus_we === 1'b1) chk("bus_wdata", bus_wdata, exp_bwdata_q.pop_front());
               else void'(exp_bwdata_q.pop_front());
            end
            k = 0;
            while (k < bm_rd && bus_valid === 1'b1) begin
               @(posedge clk); #1;
               k++;
            end
            if (bus_valid === 1'b1) begin
               bus_ready = 1'b1;
               @(posedge clk); #1;
               bus_ready = 1'b0;
               repeat (bm_vd) begin @(posedge clk); #1; end
               bus_rvalid = 1'b1; bus_rdata = bm_word; bus_err = bm_err;
               @(posedge clk); #1;
               bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom();
            end
         end
      end
   end

   initial begin : stim
      bit          we;
      bit          saw;
      logic [2:0]  f3;
      logic [31:0] a;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_bus_fields", {bus_addr[27:0], bus_wstrb}, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_req(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 0);
      do_req(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1'b0, 0, 0);
      do_req(1'b0, 3'b100, 32'h0000_0103, 32'd0, 32'h80FF_0000, 1'b0, 1, 0);
      do_req(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h80FF_0000, 1'b0, 0, 2);
      do_req(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'd0, 1'b0, 0, 0);
      do_req(1'b1, 3'b001, 32'h0000_0202, 32'h1234_56AB, 32'd0, 1'b0, 2, 1);
      do_req(1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 1'b0, 0, 0);
      do_req(1'b0, 3'b111, 32'h0000_0104, 32'd0, 32'd0, 1'b0, 0, 0);
      do_req(1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'h1111_2222, 1'b0, 300, 0);
      do_req(1'b0, 3'b010, 32'h0000_0108, 32'd0, 32'h3333_4444, 1'b1, 1, 2);

      // reset while waiting in DATA: outputs drop at once and the late response is ignored
      exp_baddr_q.push_back(32'h0000_0300); exp_bwe_q.push_back(1'b0);
      exp_bstrb_q.push_back(4'd0); exp_bwdata_q.push_back(32'd0);
      bm_rd = 0; bm_vd = 6; bm_word = 32'h5555_AAAA; bm_err = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
      req_wdata = 32'd0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      saw = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (bus_valid === 1'b1 || done === 1'b1) saw = 1'b1;
      end
      chk("rst_mid_quiet", 32'(saw), 32'd0);

      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = f3 - 3'd4;
         a = $urandom();
         do_req(we, f3, a, $urandom(), $urandom(), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      #1;
      chk("pending_responses", 32'(exp_fault_q.size()), 32'd0);
      chk("pending_bus_reqs", 32'(exp_baddr_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "time limit");
   end

endmodule
